// File: rtl/torus_noc_pkg.sv
// Shared types and constants for the torus router: flit width, input count,
// port indices and the round-robin wrap helper.
package torus_noc_pkg;

  localparam int D_W  = 32;
  localparam int N_IN = 5;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_S     = 2;
  localparam int PORT_E     = 3;
  localparam int PORT_W     = 4;

  typedef logic [D_W-1:0] flit_t;

  // Successor of a round-robin index with an explicit wrap, so the input
  // count does not have to be a power of two.
  function automatic int rr_next(input int idx, input int n);
    int nxt;
    if (idx >= n - 1) begin
      nxt = 0;
    end else begin
      nxt = idx + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/torus_port_arbiter_rr_grant.sv
// Combinational cyclic priority picker: first asserted request at or after
// ptr, wrapping past the top index back to 0. Also used by the crossbar allocator.
module rr_grant
  import torus_noc_pkg::*;
#(
  parameter int N_IN = torus_noc_pkg::N_IN,
  localparam int PTR_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_IN-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Scan offsets 0..N_IN-1 from ptr; the first valid request wins.
  always_comb begin
    gnt     = {N_IN{1'b0}};
    gnt_idx = {PTR_W{1'b0}};
    any     = 1'b0;
    w_sum   = {(PTR_W+1){1'b0}};
    w_idx   = {PTR_W{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      w_sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(N_IN)) begin
        w_sum = w_sum - (PTR_W+1)'(N_IN);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[PTR_W-1:0];
      if (en && !any && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
        any        = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/torus_port_arbiter.sv
// Output-port stage of the torus router: round-robin pick of one input beat
// per cycle into a single registered valid/data output with backpressure.
module torus_port_arbiter
  import torus_noc_pkg::*;
#(
  parameter int D_W  = torus_noc_pkg::D_W,
  parameter int N_IN = torus_noc_pkg::N_IN,
  localparam int PTR_W = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   in_v,
  input  logic [N_IN*D_W-1:0] in_d,
  output logic [N_IN-1:0]   in_b,
  output logic              o_v,
  output logic [D_W-1:0]    o_d,
  input  logic              o_b
);

  logic             r_o_v;
  logic [D_W-1:0]   r_o_d;
  logic [PTR_W-1:0] r_rr_ptr;

  logic             w_adv;
  logic             w_en;
  logic [N_IN-1:0]  w_gnt;
  logic [PTR_W-1:0] w_gnt_idx;
  logic             w_any;
  logic [D_W-1:0]   w_in_d [N_IN];
  logic [D_W-1:0]   w_sel_d;
  logic [PTR_W-1:0] w_next_ptr;

  genvar gi;
  for (gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign w_in_d[gi] = in_d[gi*D_W +: D_W];
  end

  // The register may load when empty or when its beat leaves this cycle;
  // reset gates the grant so every input sees backpressure while held.
  assign w_adv = !r_o_v || !o_b;
  assign w_en  = w_adv && rst;

  rr_grant #(
    .N_IN (N_IN)
  ) u_rr_grant (
    .req     (in_v),
    .ptr     (r_rr_ptr),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign in_b       = ~w_gnt;
  assign w_sel_d    = w_in_d[w_gnt_idx];
  assign w_next_ptr = PTR_W'(rr_next(int'(w_gnt_idx), N_IN));

  // Output beat register and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_o_v    <= 1'b0;
      r_o_d    <= {D_W{1'b0}};
      r_rr_ptr <= {PTR_W{1'b0}};
    end else if (w_adv) begin
      if (w_any) begin
        r_o_v    <= 1'b1;
        r_o_d    <= w_sel_d;
        r_rr_ptr <= w_next_ptr;
      end else begin
        r_o_v    <= 1'b0;
        r_o_d    <= r_o_d;
        r_rr_ptr <= r_rr_ptr;
      end
    end else begin
      r_o_v    <= r_o_v;
      r_o_d    <= r_o_d;
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign o_v = r_o_v;
  assign o_d = r_o_d;

endmodule

// File: tb/tb_torus_port_arbiter.sv
// Self-checking bench for torus_port_arbiter: directed vector table, hand
// sequences for stall/drain/async reset, then random traffic against a model.
module tb_torus_port_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_v;
  logic [N*DW-1:0] in_d;
  logic [N-1:0]    in_b;
  logic            o_v;
  logic [DW-1:0]   o_d;
  logic            o_b;

  logic [DW-1:0] din [N];

  int n_vec;
  int n_miss;

  // model state
  int            m_ptr;
  logic          m_ov;
  logic [DW-1:0] m_od;

  typedef struct {
    logic [N-1:0]  v;
    logic          ob;
    logic [N-1:0]  inb;
    logic          ov;
    logic [DW-1:0] od;
  } vec_t;

  localparam int NT = 17;
  vec_t tbl [NT];

  torus_port_arbiter #(.D_W(DW), .N_IN(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .in_v (in_v),
    .in_d (in_d),
    .in_b (in_b),
    .o_v  (o_v),
    .o_d  (o_d),
    .o_b  (o_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    in_d = '0;
    for (int k = 0; k < N; k++) in_d[k*DW +: DW] = din[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // One model-checked cycle; called at posedge+1.
  task automatic mstep();
    logic adv;
    int g;
    logic [N-1:0] exp_b;
    adv = !m_ov || !o_b;
    g = adv ? pick(in_v, m_ptr) : -1;
    exp_b = '1;
    if (g >= 0) exp_b[g] = 1'b0;
    #1;
    chk("rand_in_b", 32'(in_b), 32'(exp_b));
    @(posedge clk);
    #1;
    if (adv) begin
      if (g >= 0) begin
        m_ov = 1'b1;
        m_od = din[g];
        m_ptr = (g + 1) % N;
      end else begin
        m_ov = 1'b0;
      end
    end
    chk("rand_o_v", 32'(o_v), 32'(m_ov));
    chk("rand_o_d", o_d, m_od);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_ptr = 0;
    m_ov = 1'b0;
    m_od = '0;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    o_b = 1'b0;
    in_v = '1;
    for (int k = 0; k < N; k++) din[k] = 32'hA0 + 32'(k);

    tbl[0]  = '{5'b11111, 1'b0, 5'b11110, 1'b1, 32'hA0};
    tbl[1]  = '{5'b11111, 1'b0, 5'b11101, 1'b1, 32'hA1};
    tbl[2]  = '{5'b11111, 1'b0, 5'b11011, 1'b1, 32'hA2};
    tbl[3]  = '{5'b11111, 1'b0, 5'b10111, 1'b1, 32'hA3};
    tbl[4]  = '{5'b11111, 1'b0, 5'b01111, 1'b1, 32'hA4};
    tbl[5]  = '{5'b11111, 1'b0, 5'b11110, 1'b1, 32'hA0};
    tbl[6]  = '{5'b11111, 1'b0, 5'b11101, 1'b1, 32'hA1};
    tbl[7]  = '{5'b11111, 1'b0, 5'b11011, 1'b1, 32'hA2};
    tbl[8]  = '{5'b11111, 1'b0, 5'b10111, 1'b1, 32'hA3};
    tbl[9]  = '{5'b00010, 1'b0, 5'b11101, 1'b1, 32'hA1};
    tbl[10] = '{5'b00001, 1'b0, 5'b11110, 1'b1, 32'hA0};
    tbl[11] = '{5'b00000, 1'b0, 5'b11111, 1'b0, 32'hA0};
    tbl[12] = '{5'b00100, 1'b1, 5'b11011, 1'b1, 32'hA2};
    tbl[13] = '{5'b00100, 1'b1, 5'b11111, 1'b1, 32'hA2};
    tbl[14] = '{5'b01000, 1'b0, 5'b10111, 1'b1, 32'hA3};
    tbl[15] = '{5'b10001, 1'b0, 5'b01111, 1'b1, 32'hA4};
    tbl[16] = '{5'b10001, 1'b0, 5'b11110, 1'b1, 32'hA0};

    // reset held with all inputs requesting
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_v", 32'(o_v), 32'd0);
    chk("rst_o_d", o_d, 32'd0);
    chk("rst_in_b", 32'(in_b), 32'h1F);
    rst = 1'b1;

    for (int i = 0; i < NT; i++) begin
      in_v = tbl[i].v;
      o_b  = tbl[i].ob;
      #1;
      chk($sformatf("tbl%0d_in_b", i), 32'(in_b), 32'(tbl[i].inb));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_o_v", i), 32'(o_v), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_o_d", i), o_d, tbl[i].od);
    end

    // stall: hold 0x55 for 3 cycles, then load input 2 with no bubble
    o_b = 1'b0;
    in_v = '0;
    do_reset();
    din[0] = 32'h55;
    din[2] = 32'h99;
    in_v = 5'b00001;
    @(posedge clk);
    #1;
    in_v = 5'b00100;
    o_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_b", 32'(in_b), 32'h1F);
      chk("stall_o_v", 32'(o_v), 32'd1);
      chk("stall_o_d", o_d, 32'h55);
      @(posedge clk);
      #1;
    end
    o_b = 1'b0;
    #1;
    chk("unstall_in_b", 32'(in_b), 32'h1B);
    @(posedge clk);
    #1;
    in_v = '0;
    chk("unstall_o_v", 32'(o_v), 32'd1);
    chk("unstall_o_d", o_d, 32'h99);
    @(posedge clk);
    #1;
    chk("unstall_drain_o_v", 32'(o_v), 32'd0);

    // idle drain: single beat on input 3, pointer then sits at 4
    do_reset();
    din[3] = 32'h77;
    in_v = 5'b01000;
    @(posedge clk);
    #1;
    in_v = '0;
    chk("drain_o_v1", 32'(o_v), 32'd1);
    chk("drain_o_d1", o_d, 32'h77);
    @(posedge clk);
    #1;
    chk("drain_o_v0", 32'(o_v), 32'd0);
    chk("drain_o_d0", o_d, 32'h77);
    in_v = '1;
    #1;
    chk("drain_ptr4_in_b", 32'(in_b), 32'h0F);
    in_v = '0;

    // async reset in the middle of a stall
    do_reset();
    in_v = 5'b00010;
    @(posedge clk);
    #1;
    in_v = '0;
    o_b = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_o_v", 32'(o_v), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    o_b = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_after_o_v", 32'(o_v), 32'd0);
    in_v = '1;
    #1;
    chk("arst_ptr0_in_b", 32'(in_b), 32'h1E);
    in_v = '0;

    // random traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_v = N'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) in_v = '0;
      o_b = ($urandom_range(0, 9) < 3);
      for (int k = 0; k < N; k++) din[k] = $urandom;
      mstep();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
